// File: rtl/controle_reproducao_if.sv
// rtl/controle_reproducao_if.sv - Button, address and command signals of the playback sequencer
interface controle_reproducao_if #(
    parameter int unsigned ADDR_W = 22
);
    logic              play_btn;
    logic              passa_btn;
    logic              volta_btn;
    logic [ADDR_W-1:0] endereco;
    logic              count;
    logic              passa_10s;
    logic              volta_10s;
    logic              limpa_end;
    logic              tocando;
    logic              fim;

    modport master (
        output play_btn, passa_btn, volta_btn, endereco,
        input  count, passa_10s, volta_10s, limpa_end, tocando, fim
    );

    modport slave (
        input  play_btn, passa_btn, volta_btn, endereco,
        output count, passa_10s, volta_10s, limpa_end, tocando, fim
    );
endinterface

// File: rtl/controle_reproducao.sv
// rtl/controle_reproducao.sv - Playback sequencer: button edges to counter commands, sample tick, end of track
// AUTO_REPEAT_EN: when defined, end of track restarts playback instead of entering FIM.
module controle_reproducao #(
    parameter int unsigned       ADDR_W    = 22,
    parameter int unsigned       CLK_DIV   = 4,
    parameter logic [ADDR_W-1:0] END_ADDR  = 22'h3FFFFF,
    parameter logic [ADDR_W-1:0] SEEK_STEP = 22'd80000
) (
    input  logic                 clk,
    input  logic                 reset,
    controle_reproducao_if.slave bus
);
    localparam int unsigned      DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    // One bit wider so a step larger than the track shows up as a negative limit.
    localparam logic [ADDR_W:0]  PASSA_LIM = {1'b0, END_ADDR} - {1'b0, SEEK_STEP};

    typedef enum logic [1:0] {PARADO, TOCANDO, PAUSADO, FIM} estado_t;

    estado_t          state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             play_btn_q, play_btn_d;
    logic             passa_btn_q, passa_btn_d;
    logic             volta_btn_q, volta_btn_d;
    logic             passa_10s_q, passa_10s_d;
    logic             volta_10s_q, volta_10s_d;
    logic             limpa_end_q, limpa_end_d;
    logic             count_c;

    logic play_edge, passa_edge, volta_edge;
    logic end_cond, passa_ok, seek_ok;

    assign play_edge  = bus.play_btn  & ~play_btn_q;
    assign passa_edge = bus.passa_btn & ~passa_btn_q;
    assign volta_edge = bus.volta_btn & ~volta_btn_q;
    assign end_cond   = (bus.endereco >= END_ADDR);
    assign passa_ok   = ~PASSA_LIM[ADDR_W] && ({1'b0, bus.endereco} <= PASSA_LIM);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = '0;
        limpa_end_d = 1'b0;
        passa_10s_d = 1'b0;
        volta_10s_d = 1'b0;
        count_c     = 1'b0;
        seek_ok     = 1'b0;
        play_btn_d  = bus.play_btn;
        passa_btn_d = bus.passa_btn;
        volta_btn_d = bus.volta_btn;

        case (state_q)
            PARADO: begin
                if (play_edge) begin
                    state_d     = TOCANDO;
                    limpa_end_d = 1'b1;
                end
            end
            TOCANDO: begin
                // End of track wins over play and seek in the same cycle.
                if (end_cond) begin
`ifdef AUTO_REPEAT_EN
                    limpa_end_d = 1'b1;
`else
                    state_d     = FIM;
`endif
                end else begin
                    count_c   = (div_cnt_q == DIV_LAST);
                    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
                    seek_ok   = 1'b1;
                    if (play_edge) begin
                        state_d   = PAUSADO;
                        div_cnt_d = '0;
                    end
                end
            end
            PAUSADO: begin
                seek_ok = 1'b1;
                if (play_edge) begin
                    state_d = TOCANDO;
                end
            end
            FIM: begin
                if (play_edge) begin
                    state_d     = TOCANDO;
                    limpa_end_d = 1'b1;
                end
            end
            default: state_d = PARADO;
        endcase

        // Simultaneous +10 s and -10 s edges cancel each other.
        if (seek_ok && passa_edge && !volta_edge && passa_ok) begin
            passa_10s_d = 1'b1;
        end
        if (seek_ok && volta_edge && !passa_edge) begin
            volta_10s_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PARADO;
            div_cnt_q   <= '0;
            play_btn_q  <= 1'b0;
            passa_btn_q <= 1'b0;
            volta_btn_q <= 1'b0;
            passa_10s_q <= 1'b0;
            volta_10s_q <= 1'b0;
            limpa_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            play_btn_q  <= play_btn_d;
            passa_btn_q <= passa_btn_d;
            volta_btn_q <= volta_btn_d;
            passa_10s_q <= passa_10s_d;
            volta_10s_q <= volta_10s_d;
            limpa_end_q <= limpa_end_d;
        end
    end

    assign bus.count     = count_c;
    assign bus.passa_10s = passa_10s_q;
    assign bus.volta_10s = volta_10s_q;
    assign bus.limpa_end = limpa_end_q;
    assign bus.tocando   = (state_q == TOCANDO);
`ifdef AUTO_REPEAT_EN
    assign bus.fim       = 1'b0;
`else
    assign bus.fim       = (state_q == FIM);
`endif

endmodule

// File: doc/controle_reproducao.md
# controle_reproducao

Playback sequencer for the audio-address counter of the music player. Converts raw play/pause and ±10 s button levels into one-cycle command pulses, generates the sample-rate `count` enable, and detects end of track from the fed-back address. Sits between the button synchronisers and the current-address counter, whose `passa_10s`, `volta_10s`, `count` and `reset` inputs it drives.

## Interface
- `ADDR_W`, 22: address width, matching the address counter.
- `CLK_DIV`, 4: clock cycles per sample tick; must be ≥ 2.
- `END_ADDR`, 22'h3FFFFF: last valid sample address of the track.
- `SEEK_STEP`, 22'd80000: address distance of one +10 s jump, used only for the near-end guard.

- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `play_btn`  in  1: play/pause button level, already synchronised.
- `passa_btn`  in  1: +10 s button level, already synchronised.
- `volta_btn`  in  1: −10 s button level, already synchronised.
- `endereco`  in  ADDR_W: current address fed back from the counter.
- `count`  out  1: counter advance enable, one-cycle pulse per sample.
- `passa_10s`  out  1: one-cycle +10 s command to the counter.
- `volta_10s`  out  1: one-cycle −10 s command to the counter.
- `limpa_end`  out  1: one-cycle active-high clear to the counter's `reset`.
- `tocando`  out  1: high in state TOCANDO.
- `fim`  out  1: high in state FIM.

## Operation
- Edge detect: each button is registered into `*_q`. An edge is `btn & ~btn_q`; only edges act, and held levels do nothing.
- States:
  - PARADO: reset state.
  - TOCANDO
  - PAUSADO
  - FIM
- Transitions (at most one per cycle):
  - PARADO + play edge → TOCANDO, with a `limpa_end` pulse.
  - TOCANDO + play edge → PAUSADO.
  - PAUSADO + play edge → TOCANDO.
  - TOCANDO with `endereco >= END_ADDR` → FIM. This has priority over the play edge and over seeks in the same cycle.
  - FIM + play edge → TOCANDO, with a `limpa_end` pulse.
- Prescaler `div_cnt` (width ceil(log2(CLK_DIV))):
  - Counts 0..CLK_DIV−1 and wraps, only in TOCANDO.
  - Cleared to 0 on every entry to TOCANDO and held at 0 in all other states.
  - `count` = (state == TOCANDO) & (div_cnt == CLK_DIV−1) & no end condition that cycle.
- Seek:
  - Accepted only in TOCANDO or PAUSADO.
  - A `passa` edge and a `volta` edge in the same cycle are both ignored.
  - `passa` is ignored when `endereco > END_ADDR − SEEK_STEP`; compute in ADDR_W+1 bits and treat a negative result as always-ignore.
  - `volta` is always forwarded; the counter saturates at 0.
  - Seeks do not disturb `div_cnt`.
- Mutual exclusion: `passa_10s`, `volta_10s` and `limpa_end` are never high in the same cycle.

## Timing
- Reset values: all outputs 0, state PARADO, `div_cnt` 0, `*_q` 0.
- Release of reset is synchronous to `clk`.
- Button edge at rising edge N → `passa_10s`, `volta_10s`, `limpa_end` or the state change is visible after edge N+1 (registered outputs, latency 1).
- First `count` pulse: in cycle CLK_DIV after entering TOCANDO. Thereafter one pulse every CLK_DIV cycles.
- End detection: `endereco` reaching END_ADDR is sampled at edge M. `fim` is high and `count` is low from edge M+1. No `count` pulse is issued in cycle M itself.
- Reset asserted mid-operation: all outputs drop to 0 immediately (asynchronous), with no partial pulses.

## Configuration
- `AUTO_REPEAT_EN`
  - Defined: the end condition in TOCANDO issues a `limpa_end` pulse and stays in TOCANDO. `div_cnt` is cleared, and FIM is unreachable, so `fim` is constant 0.
  - Undefined: transitions to FIM as described in Operation.

## Test plan
All scenarios use CLK_DIV=4, END_ADDR=100, SEEK_STEP=10.

- Reset then play edge → `limpa_end` high exactly 1 cycle. `tocando`=1. `count` pulses at cycles 4, 8, 12 after entry and never 2 cycles in a row.
- Hold `passa_btn` high for 50 cycles with `endereco`=40 in TOCANDO → exactly one `passa_10s` pulse. Repeat with `endereco`=95 → no pulse. Repeat with `volta_btn` rising in the same cycle → neither pulse.
- Play edge in TOCANDO → PAUSADO, `count` stays 0 for 100 cycles. `volta_btn` edge → one `volta_10s` pulse. Play edge → first `count` 4 cycles after re-entry.
- Drive `endereco`=100 in TOCANDO, coincident with a play edge → `fim`=1 next cycle, `count`=0, state not PAUSADO. Play edge → `limpa_end` pulse, `tocando`=1.
- With `AUTO_REPEAT_EN` defined, `endereco`=100 → `limpa_end` pulse, `tocando` stays 1, `fim` never 1.
- Assert `reset` low in the cycle a `count` pulse is due → `count` and all outputs 0 immediately. After release, state is PARADO and no output toggles without a play edge.
